// File: rtl/jtag_scan_master.sv
// JTAG host initiator: each START shifts one instruction through Shift-IR, then up to DR_MAX bits
// through Shift-DR (capturing TDO into DR_OUT), and parks the target in Run-Test/Idle.
module jtag_scan_master #(
  parameter int IR_WIDTH = 4,
  parameter int DR_MAX   = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [IR_WIDTH-1:0] IR_VALUE,
  input  logic [5:0]          DR_LEN,
  input  logic [DR_MAX-1:0]   DR_IN,
  output logic                READY,
  output logic                BUSY,
  output logic                DONE,
  output logic [DR_MAX-1:0]   DR_OUT,
  output logic                TCK,
  output logic                TMS,
  output logic                TDI,
  input  logic                TDO
);

  localparam int MAX_LEN = (IR_WIDTH > DR_MAX) ? IR_WIDTH : DR_MAX;
  // INIT counts up to 5, so the bit counter never shrinks below 3 bits
  localparam int CW = (($clog2(MAX_LEN) + 1) > 3) ? ($clog2(MAX_LEN) + 1) : 3;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_IR_SEL,
    S_IR_SHIFT,
    S_IR_UPD,
    S_DR_SEL,
    S_DR_SHIFT,
    S_DR_UPD,
    S_RTI_RET
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       len_q, len_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_MAX-1:0]   dr_sh_q, dr_sh_d;
  logic [DR_MAX-1:0]   dr_out_q, dr_out_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                active_s, tick_s, rise_s, fall_s;
  logic [CW-1:0]       len_clamp_s;

  assign active_s    = (state_q != S_IDLE);
  assign tick_s      = active_s && (div_q == DW'(CLK_DIV - 1));
  assign rise_s      = tick_s && !tck_q;
  assign fall_s      = tick_s && tck_q;
  assign len_clamp_s = ({26'd0, DR_LEN} > 32'(DR_MAX)) ? CW'(DR_MAX) : CW'(DR_LEN);

  // Next-state: TCK divider, TDO capture on rising TCK, sequencing on falling TCK
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ir_d     = ir_q;
    dr_sh_d  = dr_sh_q;
    dr_out_d = dr_out_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (tick_s) begin
      div_d = {DW{1'b0}};
      tck_d = ~tck_q;
    end else if (active_s) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = {DW{1'b0}};
    end

    if (rise_s && (state_q == S_DR_SHIFT)) begin
      dr_out_d = dr_out_q | (DR_MAX'(TDO) << cnt_q);
    end else begin
      dr_out_d = dr_out_q;
    end

    if (state_q == S_IDLE) begin
      if (START && ready_q) begin
        state_d  = S_IR_SEL;
        cnt_d    = {CW{1'b0}};
        len_d    = len_clamp_s;
        ir_d     = IR_VALUE;
        dr_sh_d  = DR_IN;
        dr_out_d = {DR_MAX{1'b0}};
        tms_d    = 1'b1;
        tdi_d    = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else if (fall_s) begin
      // tms_d/tdi_d are the values the target sees on the next rising TCK
      case (state_q)
        S_INIT: begin
          if (cnt_q == CW'(5)) begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
            tms_d   = 1'b0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            tms_d = (cnt_q < CW'(4));
          end
        end
        S_IR_SEL: begin
          if (cnt_q == CW'(3)) begin
            state_d = S_IR_SHIFT;
            cnt_d   = {CW{1'b0}};
            tdi_d   = ir_q[0];
            ir_d    = ir_q >> 1;
            tms_d   = (IR_WIDTH == 1);
          end else begin
            cnt_d = cnt_q + CW'(1);
            tms_d = (cnt_q == CW'(0));
          end
        end
        S_IR_SHIFT: begin
          if (cnt_q == CW'(IR_WIDTH - 1)) begin
            state_d = S_IR_UPD;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            tdi_d = ir_q[0];
            ir_d  = ir_q >> 1;
            tms_d = (cnt_q == CW'(IR_WIDTH - 2));
          end
        end
        S_IR_UPD: begin
          cnt_d = {CW{1'b0}};
          if (len_q == {CW{1'b0}}) begin
            state_d = S_RTI_RET;
            tms_d   = 1'b0;
          end else begin
            state_d = S_DR_SEL;
            tms_d   = 1'b1;
          end
        end
        S_DR_SEL: begin
          if (cnt_q == CW'(2)) begin
            state_d = S_DR_SHIFT;
            cnt_d   = {CW{1'b0}};
            tdi_d   = dr_sh_q[0];
            dr_sh_d = dr_sh_q >> 1;
            tms_d   = (len_q == CW'(1));
          end else begin
            cnt_d = cnt_q + CW'(1);
            tms_d = 1'b0;
          end
        end
        S_DR_SHIFT: begin
          if (cnt_q == (len_q - CW'(1))) begin
            state_d = S_DR_UPD;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            tdi_d   = dr_sh_q[0];
            dr_sh_d = dr_sh_q >> 1;
            tms_d   = (cnt_q == (len_q - CW'(2)));
          end
        end
        S_DR_UPD: begin
          state_d = S_RTI_RET;
          tms_d   = 1'b0;
        end
        S_RTI_RET: begin
          state_d = S_IDLE;
          tms_d   = 1'b0;
          tdi_d   = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_INIT;
          cnt_d   = {CW{1'b0}};
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_INIT;
      div_q    <= {DW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      len_q    <= {CW{1'b0}};
      ir_q     <= {IR_WIDTH{1'b0}};
      dr_sh_q  <= {DR_MAX{1'b0}};
      dr_out_q <= {DR_MAX{1'b0}};
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ir_q     <= ir_d;
      dr_sh_q  <= dr_sh_d;
      dr_out_q <= dr_out_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign READY  = ready_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DR_OUT = dr_out_q;
  assign TCK    = tck_q;
  assign TMS    = tms_q;
  assign TDI    = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural IEEE 1149.1 TAP target plus a scoreboard that derives
// TMS/TDI sequences, TCK counts and DR_OUT from the scan rules with plain arithmetic.
module tb_jtag_scan_master;
  localparam int IR_WIDTH = 4;
  localparam int DR_MAX   = 32;
  localparam int CLK_DIV  = 4;
  localparam int LOG_N    = 4096;
  localparam logic [31:0] IDCODE   = 32'h1234_5677;
  localparam logic [31:0] USER_RST = 32'hA5A5_0F0F;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                START;
  logic [IR_WIDTH-1:0] IR_VALUE;
  logic [5:0]          DR_LEN;
  logic [DR_MAX-1:0]   DR_IN;
  logic                READY, BUSY, DONE, TCK, TMS, TDI;
  logic [DR_MAX-1:0]   DR_OUT;
  logic                TDO = 1'b0;

  jtag_scan_master #(.IR_WIDTH(IR_WIDTH), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IR_VALUE(IR_VALUE), .DR_LEN(DR_LEN),
    .DR_IN(DR_IN), .READY(READY), .BUSY(BUSY), .DONE(DONE), .DR_OUT(DR_OUT),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PA_DR;
      PA_DR:   return tms ? EX2_DR : PA_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PA_IR;
      PA_IR:   return tms ? EX2_IR : PA_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  // Target TAP: starts in an arbitrary non-reset state; TLR selects IDCODE
  tap_e        tap_st     = PA_DR;
  logic [3:0]  tap_ir     = 4'h7;
  logic [3:0]  ir_sr      = 4'h0;
  logic [31:0] dr_sr      = 32'h0;
  logic [31:0] user_reg   = USER_RST;
  int          tck_rises  = 0;
  int          shdr_rises = 0;
  int          tlr_cnt    = 0;
  logic        tms_log [0:LOG_N-1];
  logic        tdi_log [0:LOG_N-1];
  longint      rise_t  [0:LOG_N-1];

  always @(posedge TCK) begin
    if (tck_rises < LOG_N) begin
      tms_log[tck_rises] <= TMS;
      tdi_log[tck_rises] <= TDI;
      rise_t[tck_rises]  <= longint'($time);
    end
    tck_rises <= tck_rises + 1;
    case (tap_st)
      TLR:    tap_ir <= 4'h7;
      CAP_IR: ir_sr <= 4'b0001;
      SH_IR:  ir_sr <= {TDI, ir_sr[3:1]};
      UPD_IR: tap_ir <= ir_sr;
      CAP_DR: dr_sr <= (tap_ir == 4'h7) ? IDCODE : ((tap_ir == 4'hF) ? 32'h0 : user_reg);
      SH_DR: begin
        shdr_rises <= shdr_rises + 1;
        dr_sr <= (tap_ir == 4'hF) ? {31'h0, TDI} : {TDI, dr_sr[31:1]};
      end
      UPD_DR: if (tap_ir != 4'h7 && tap_ir != 4'hF) user_reg <= dr_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, TMS);
    if (tap_next(tap_st, TMS) == TLR) tlr_cnt <= tlr_cnt + 1;
  end

  always @(negedge TCK) begin
    TDO <= (tap_st == SH_DR) ? dr_sr[0] : ((tap_st == SH_IR) ? ir_sr[0] : 1'b0);
  end

  int done_cnt = 0;
  always @(posedge CLK) begin
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_user = USER_RST;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (READY !== 1'b1 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    ok = (READY === 1'b1);
  endtask

  task automatic run_scan(input logic [3:0] ir, input int len, input logic [31:0] din, input bit poke);
    int base, d0, lc, n, p, k, bad_per;
    bit ok;
    logic [63:0] etms, etdi, gtms, gtdi, m;
    logic [31:0] exp_out;
    wait_ready(ok);
    check("ready_before_start", 64'(ok), 64'd1);
    base = tck_rises;
    d0   = done_cnt;
    @(negedge CLK);
    IR_VALUE = ir; DR_LEN = 6'(len); DR_IN = din; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_accept", {63'd0, BUSY}, 64'd1);
    check("ready_after_accept", {63'd0, READY}, 64'd0);
    if (poke) begin
      repeat (20) @(negedge CLK);
      IR_VALUE = 4'h1; DR_LEN = 6'd3; DR_IN = ~din; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 4000) begin
      @(negedge CLK);
      k++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    check("end_ready", {63'd0, READY}, 64'd1);
    check("end_busy", {63'd0, BUSY}, 64'd0);
    check("end_tms_tdi_tck", {61'd0, TMS, TDI, TCK}, 64'd0);
    repeat (40) @(negedge CLK);

    lc = (len > DR_MAX) ? DR_MAX : len;
    n  = (lc == 0) ? (6 + IR_WIDTH) : (10 + IR_WIDTH + lc);
    etms = 64'd0; etdi = 64'd0; p = 0;
    etms[0] = 1'b1; etms[1] = 1'b1; p = 4;
    for (int i = 0; i < IR_WIDTH; i++) begin
      etms[p] = (i == IR_WIDTH - 1); etdi[p] = ir[i]; p++;
    end
    etms[p] = 1'b1; p++;
    if (lc != 0) begin
      etms[p] = 1'b1; p += 3;
      for (int i = 0; i < lc; i++) begin
        etms[p] = (i == lc - 1); etdi[p] = din[i]; p++;
      end
      etms[p] = 1'b1; p++;
    end
    gtms = 64'd0; gtdi = 64'd0; bad_per = 0;
    for (int i = 0; i < n && i < 64 && base + i < LOG_N; i++) begin
      gtms[i] = tms_log[base + i];
      gtdi[i] = tdi_log[base + i];
      if (i > 0 && rise_t[base + i] - rise_t[base + i - 1] != longint'(2 * CLK_DIV * 10)) bad_per++;
    end

    m = (64'd1 << lc) - 64'd1;
    if (lc == 0) exp_out = 32'h0;
    else if (ir == 4'h7) exp_out = IDCODE & m[31:0];
    else if (ir == 4'hF) exp_out = (din << 1) & m[31:0];
    else exp_out = exp_user & m[31:0];

    check("tck_count", 64'(tck_rises - base), 64'(n));
    check("tms_seq", gtms, etms);
    check("tdi_seq", gtdi, etdi);
    check("tck_period", 64'(bad_per), 64'd0);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("dr_out", {32'd0, DR_OUT}, {32'd0, exp_out});
    check("tap_rti", {60'd0, tap_st}, {60'd0, RTI});
    check("tap_ir", {60'd0, tap_ir}, {60'd0, ir});
    check("idle_after", {62'd0, READY, BUSY}, 64'd2);
    if (lc != 0 && ir != 4'h7 && ir != 4'hF) begin
      if (lc == 32) exp_user = din;
      else exp_user = (exp_user >> lc) | (din << (32 - lc));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, d0, s0, k;
    bit ok, early;
    logic [63:0] g;
    RST_N = 1'b0; START = 1'b0; IR_VALUE = 4'h0; DR_LEN = 6'd0; DR_IN = 32'h0;
    repeat (3) @(negedge CLK);
    check("rst_tck", {63'd0, TCK}, 64'd0);
    check("rst_tms", {63'd0, TMS}, 64'd1);
    check("rst_tdi", {63'd0, TDI}, 64'd0);
    check("rst_ready_busy_done", {61'd0, READY, BUSY, DONE}, 64'd0);
    check("rst_dr_out", {32'd0, DR_OUT}, 64'd0);

    // Initialisation sequence after reset release
    base = tck_rises; t0 = tlr_cnt; early = 1'b0; k = 0;
    RST_N = 1'b1;
    while (READY !== 1'b1 && k < 1000) begin
      @(negedge CLK);
      k++;
      if (tck_rises - base == 6 && TCK === 1'b1) early |= READY;
    end
    check("init_ready", {63'd0, READY}, 64'd1);
    check("init_ready_early", {63'd0, early}, 64'd0);
    check("init_rises", 64'(tck_rises - base), 64'd6);
    g = 64'd0;
    for (int i = 0; i < 6; i++) g[i] = tms_log[base + i];
    check("init_tms", g, 64'h1F);
    g = 64'd0;
    for (int i = 1; i < 6; i++) if (rise_t[base + i] - rise_t[base + i - 1] != longint'(2 * CLK_DIV * 10)) g++;
    check("init_period", g, 64'd0);
    check("init_tap_rti", {60'd0, tap_st}, {60'd0, RTI});
    check("init_tlr_seen", 64'(tlr_cnt > t0), 64'd1);
    base = tck_rises;
    repeat (30) @(negedge CLK);
    check("idle_tck_quiet", 64'(tck_rises - base), 64'd0);

    run_scan(4'h7, 32, 32'($urandom), 1'b0);
    run_scan(4'hF, 1, 32'h1, 1'b0);
    run_scan(4'h2, 0, 32'($urandom), 1'b0);
    run_scan(4'h1, 40, 32'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_scan(4'($urandom_range(0, 15)), int'($urandom_range(0, 40)), 32'($urandom), 1'b0);
    end

    // Abort in the middle of a DR shift
    wait_ready(ok);
    s0 = shdr_rises; d0 = done_cnt;
    @(negedge CLK);
    IR_VALUE = 4'h7; DR_LEN = 6'd32; DR_IN = 32'($urandom); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (shdr_rises - s0 < 2 && k < 4000) begin
      @(negedge CLK);
      k++;
    end
    check("abort_reach_shift", 64'(shdr_rises - s0), 64'd2);
    RST_N = 1'b0;
    #1;
    check("abort_tck", {63'd0, TCK}, 64'd0);
    check("abort_tms", {63'd0, TMS}, 64'd1);
    check("abort_ready_busy_done", {61'd0, READY, BUSY, DONE}, 64'd0);
    check("abort_dr_out", {32'd0, DR_OUT}, 64'd0);
    repeat (4) @(negedge CLK);
    t0 = tlr_cnt;
    RST_N = 1'b1;
    wait_ready(ok);
    check("abort_reinit_ready", 64'(ok), 64'd1);
    check("abort_tlr_seen", 64'(tlr_cnt > t0), 64'd1);
    check("abort_tap_rti", {60'd0, tap_st}, {60'd0, RTI});
    check("abort_tap_ir", {60'd0, tap_ir}, 64'h7);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_scan(4'h7, 32, 32'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
